// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and default datapath width
// for the sequential ALU execution stage.
package cpu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Signed restoring divider on operand magnitudes with a
// final sign-fix cycle and a zero-latency divide-by-zero path.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sa_q, sa_d;
  logic             sq_q, sq_d;

  logic             b_zero;
  logic [WIDTH:0]   tmp;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    sa_d   = sa_q;
    sq_d   = sq_q;
    b_zero = (b == '0);
    mag_a  = a[WIDTH-1] ? -a : a;
    mag_b  = b[WIDTH-1] ? -b : b;
    tmp    = {rem_q, quo_q[WIDTH-1]};
    diff   = tmp - {1'b0, dvs_q};
    done   = 1'b0;
    quo    = '0;
    rem    = '0;
    unique case (st_q)
      ST_IDLE: begin
        if (start && b_zero) begin
          done = 1'b1;
          quo  = '1;
          rem  = a;
        end else if (start) begin
          st_d  = ST_DIV;
          cnt_d = '0;
          rem_d = '0;
          quo_d = mag_a;
          dvs_d = mag_b;
          sa_d  = a[WIDTH-1];
          sq_d  = a[WIDTH-1] ^ b[WIDTH-1];
        end
      end
      ST_DIV: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = tmp[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          st_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // quotient truncates to zero, remainder follows a
        done = 1'b1;
        quo  = sq_q ? -quo_q : quo_q;
        rem  = sa_q ? -rem_q : rem_q;
        st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sa_q  <= 1'b0;
      sq_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      sa_q  <= sa_d;
      sq_q  <= sq_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execution stage: single-cycle logic/shift/add ops, Booth
// multiply and a sequential divider, results on z_hi:z_lo.
module alu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   mcd_q, mcd_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             q1_q, q1_d;
  logic             busy_q, busy_d;
  logic             stg_vld_q, stg_vld_d;
  logic [WIDTH-1:0] stg_hi_q, stg_hi_d;
  logic [WIDTH-1:0] stg_lo_q, stg_lo_d;
  logic [WIDTH-1:0] z_hi_q, z_hi_d;
  logic [WIDTH-1:0] z_lo_q, z_lo_d;
  logic             done_q, done_d;

  logic               go;
  logic               div_start;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [4:0]         sh;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;
  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   mq_n;

  assign go = start & ~busy_q
            & (state_q == ST_IDLE);
  assign div_start = go & (op == OP_DIV);

  seq_divider #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_div (
    .clock(clock),
    .clear(clear),
    .start(div_start),
    .a    (a),
    .b    (b),
    .done (div_done),
    .quo  (div_quo),
    .rem  (div_rem)
  );

  always_comb begin
    sh    = b[4:0];
    rot_r = {a, a} >> sh;
    rot_l = {a, a} << sh;
    case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SHR:  sc_res = a >> sh;
      OP_SHRA: sc_res = $signed(a) >>> sh;
      OP_SHL:  sc_res = a << sh;
      OP_ROR:  sc_res = rot_r[WIDTH-1:0];
      OP_ROL:  sc_res = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:  sc_res = -b;
      OP_NOT:  sc_res = ~b;
      default: sc_res = '0;
    endcase
  end

  // one Booth step: add/sub multiplicand, then arithmetic shift
  always_comb begin
    unique case ({mq_q[0], q1_q})
      2'b01:   sum = acc_q + mcd_q;
      2'b10:   sum = acc_q - mcd_q;
      default: sum = acc_q;
    endcase
    acc_n = {sum[WIDTH], sum[WIDTH:1]};
    mq_n  = {sum[0], mq_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcd_d     = mcd_q;
    mq_d      = mq_q;
    q1_d      = q1_q;
    busy_d    = stg_vld_q ? 1'b0 : busy_q;
    stg_vld_d = 1'b0;
    stg_hi_d  = stg_hi_q;
    stg_lo_d  = stg_lo_q;
    z_hi_d    = stg_vld_q ? stg_hi_q : z_hi_q;
    z_lo_d    = stg_vld_q ? stg_lo_q : z_lo_q;
    done_d    = stg_vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go && op == OP_MUL) begin
          state_d = ST_MUL;
          busy_d  = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          mcd_d   = {a[WIDTH-1], a};
          mq_d    = b;
          q1_d    = 1'b0;
        end else if (go && op == OP_DIV) begin
          if (!div_done) begin
            state_d = ST_DIV;
            busy_d  = 1'b1;
          end
        end else if (go) begin
          stg_vld_d = 1'b1;
          stg_hi_d  = '0;
          stg_lo_d  = sc_res;
        end
      end
      ST_MUL: begin
        acc_d = acc_n;
        mq_d  = mq_n;
        q1_d  = mq_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          stg_vld_d = 1'b1;
          stg_hi_d  = acc_n[WIDTH-1:0];
          stg_lo_d  = mq_n;
        end
      end
      default: begin
        if (div_done) state_d = ST_IDLE;
      end
    endcase
    if (div_done) begin
      stg_vld_d = 1'b1;
      stg_hi_d  = div_rem;
      stg_lo_d  = div_quo;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcd_q     <= '0;
      mq_q      <= '0;
      q1_q      <= 1'b0;
      busy_q    <= 1'b0;
      stg_vld_q <= 1'b0;
      stg_hi_q  <= '0;
      stg_lo_q  <= '0;
      z_hi_q    <= '0;
      z_lo_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcd_q     <= mcd_d;
      mq_q      <= mq_d;
      q1_q      <= q1_d;
      busy_q    <= busy_d;
      stg_vld_q <= stg_vld_d;
      stg_hi_q  <= stg_hi_d;
      stg_lo_q  <= stg_lo_d;
      z_hi_q    <= z_hi_d;
      z_lo_q    <= z_lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q & ~clear;
  assign z_hi = z_hi_q;
  assign z_lo = z_lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq against an
// arithmetic reference model.
module tb_alu_seq;

  logic        clock;
  logic        clear;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] z_hi;
  logic [31:0] z_lo;

  typedef struct {
    logic [63:0] z;
    int unsigned at_edge;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  alu_seq dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .z_hi (z_hi),
    .z_lo (z_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] model(
    input logic [3:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    int          sh;
    logic [31:0] lo;
    longint      p;
    longint      qa;
    longint      qb;
    longint      qq;
    longint      rr;
    sh = int'(y[4:0]);
    lo = 32'h0;
    case (o)
      4'd0:  lo = x + y;
      4'd1:  lo = x - y;
      4'd2:  lo = x & y;
      4'd3:  lo = x | y;
      4'd4:  lo = x >> sh;
      4'd5:  lo = $signed(x) >>> sh;
      4'd6:  lo = x << sh;
      4'd7:  lo = (x >> sh) | (x << (32 - sh));
      4'd8:  lo = (x << sh) | (x >> (32 - sh));
      4'd9: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      4'd10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        qa = longint'($signed(x));
        qb = longint'($signed(y));
        qq = qa / qb;
        rr = qa % qb;
        return {rr[31:0], qq[31:0]};
      end
      4'd11: lo = -y;
      4'd12: lo = ~y;
      default: lo = 32'h0;
    endcase
    return {32'h0, lo};
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic wait_done(input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL done_timeout: got no done expected done within %0d", n);
    end
  endtask

  task automatic push_exp(
    input logic [3:0] o,
    input logic [31:0] x,
    input logic [31:0] y,
    output int lat
  );
    exp_t e;
    if (o == 4'd9) lat = 33;
    else if (o == 4'd10 && y != 0) lat = 34;
    else lat = 1;
    e.z = model(o, x, y);
    e.at_edge = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic run_op(
    input logic [3:0] o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    int lat;
    push_exp(o, x, y, lat);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(lat > 1));
    wait_done(lat + 4);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (clear) begin
        compared++;
        mismatched++;
        $display("FAIL done_with_clear: got 1 expected 0");
      end else if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        e = sb.pop_front();
        chk("z", {z_hi, z_lo}, e.z);
        chk("done_cycle", 64'(cyc), 64'(e.at_edge));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [3:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int unsigned sel;
    clear = 1'b1;
    start = 1'b0;
    op = 4'd0;
    a = 32'h0;
    b = 32'h0;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_z", {z_hi, z_lo}, 64'd0);
    @(negedge clock);

    run_op(4'd0, 32'd5, 32'd7);
    run_op(4'd7, 32'h1, 32'h1);
    run_op(4'd9, 32'hFFFF_FFFE, 32'd3);
    run_op(4'd10, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd10, 32'd7, 32'd0);
    run_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd13, 32'h1234, 32'h5678);

    // start during MUL must be dropped
    push_exp(4'd9, 32'd3, 32'd4, lat);
    start = 1'b1;
    op = 4'd9;
    a = 32'd3;
    b = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start = 1'b1;
    op = 4'd0;
    a = 32'd1;
    b = 32'd1;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat + 4);
    repeat (4) @(negedge clock);

    // clear aborts a MUL in flight
    push_exp(4'd9, 32'd123, 32'd456, lat);
    start = 1'b1;
    op = 4'd9;
    a = 32'd123;
    b = 32'd456;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    sb.delete();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_z", {z_hi, z_lo}, 64'd0);
    repeat (40) @(negedge clock);
    run_op(4'd0, 32'd2, 32'd2);

    // ADD issued in the DIV done cycle
    run_op(4'd10, 32'd100, 32'hFFFF_FFF9);
    run_op(4'd0, 32'hFFFF_FFFF, 32'd2);

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 32'h0;
      if (sel == 1) ry = 32'($urandom_range(0, 40));
      if (sel == 2) begin
        rx = 32'h8000_0000;
        ry = 32'hFFFF_FFFF;
      end
      if (sel == 3) rx = 32'($urandom_range(0, 9));
      run_op(ro, rx, ry);
    end

    repeat (5) @(negedge clock);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
